// File: rtl/sha256_pkg.sv
// SHA-256 shared constants: widths, round constant table, sigma helpers, schedule FSM states.
package sha256_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 512;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ROUND = 2'd2
  } state_e;

  localparam logic [WORD_W-1:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x,
                                             input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic logic [WORD_W-1:0] sigma0(input logic [WORD_W-1:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [WORD_W-1:0] sigma1(input logic [WORD_W-1:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_w_expand.sv
// Combinational message-schedule expansion: W[t] from W[t-2], W[t-7], W[t-15], W[t-16].
module sha256_w_expand
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] w_m2_i,
  input  logic [WORD_W-1:0] w_m7_i,
  input  logic [WORD_W-1:0] w_m15_i,
  input  logic [WORD_W-1:0] w_m16_i,
  output logic [WORD_W-1:0] w_o
);

  // Sum of the four schedule terms, modulo 2^32.
  always_comb begin
    w_o = sigma1(w_m2_i) + w_m7_i + sigma0(w_m15_i) + w_m16_i;
  end

endmodule

// File: rtl/sha256_msg_sched.sv
// SHA-256 message scheduler: accepts one 512-bit block, strobes load, then streams
// W0..W63 with K0..K63 one round per cycle, expanding in a 16-word circular buffer.
module sha256_msg_sched
  import sha256_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              blk_valid_i,
  output logic              blk_ready_o,
  input  logic [BLK_W-1:0]  blk_i,
  output logic              load_o,
  output logic              wt_valid_o,
  output logic [WORD_W-1:0] Wt_o,
  output logic [WORD_W-1:0] Kt_o,
  output logic [5:0]        round_o,
  output logic              last_o
);

  state_e            state_q, state_d;
  logic [5:0]        t_q, t_d;
  logic [WORD_W-1:0] msg_q [16];

  logic [15:0][WORD_W-1:0] blk_words;
  logic [3:0]        idx_m2, idx_m7, idx_m15, idx_cur;
  logic [WORD_W-1:0] w_exp;
  logic [WORD_W-1:0] w_cur;
  logic              accept;

  assign blk_words = blk_i;
  assign accept    = blk_valid_i && blk_ready_o;

  // 4-bit index arithmetic wraps naturally, giving the mod-16 buffer positions;
  // idx_cur doubles as the t-16 slot that gets overwritten.
  assign idx_cur = t_q[3:0];
  assign idx_m2  = t_q[3:0] - 4'd2;
  assign idx_m7  = t_q[3:0] - 4'd7;
  assign idx_m15 = t_q[3:0] - 4'd15;

  sha256_w_expand u_expand (
    .w_m2_i  (msg_q[idx_m2]),
    .w_m7_i  (msg_q[idx_m7]),
    .w_m15_i (msg_q[idx_m15]),
    .w_m16_i (msg_q[idx_cur]),
    .w_o     (w_exp)
  );

  // Select raw message word for the first 16 rounds, expanded word afterwards.
  always_comb begin
    w_cur = msg_q[idx_cur];
    if (t_q[5:4] != 2'b00) begin
      w_cur = w_exp;
    end
  end

  // Next-state and round counter; exit decided on t==63, never on overflow.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    unique case (state_q)
      IDLE: begin
        t_d = '0;
        if (accept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        state_d = ROUND;
        t_d     = '0;
      end
      ROUND: begin
        if (t_q == 6'd63) begin
          state_d = IDLE;
          t_d     = '0;
        end else begin
          t_d = t_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  // State, counter and circular message buffer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      t_q     <= '0;
      for (int unsigned i = 0; i < 16; i++) begin
        msg_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      if (state_q == IDLE && accept) begin
        for (int unsigned i = 0; i < 16; i++) begin
          msg_q[4'(i)] <= blk_words[4'(15 - i)];
        end
      end else if (state_q == ROUND && t_q[5:4] != 2'b00) begin
        msg_q[idx_cur] <= w_exp;
      end
    end
  end

  // Output decode from registered state; round outputs forced to zero outside ROUND.
  always_comb begin
    blk_ready_o = 1'b0;
    load_o      = 1'b0;
    wt_valid_o  = 1'b0;
    Wt_o        = '0;
    Kt_o        = '0;
    round_o     = '0;
    last_o      = 1'b0;
    unique case (state_q)
      IDLE:  blk_ready_o = 1'b1;
      LOAD:  load_o      = 1'b1;
      ROUND: begin
        wt_valid_o = 1'b1;
        Wt_o       = w_cur;
        Kt_o       = K[t_q];
        round_o    = t_q;
        last_o     = (t_q == 6'd63);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sha256_msg_sched.sv
// Directed bench for sha256_msg_sched: reset, "abc" stream checked by a local
// compression model against the known digest, back-to-back, mid-run reset, ignored valid.
module tb_sha256_msg_sched;

  logic         clk = 1'b0;
  logic         rst;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk;
  logic         load;
  logic         wt_valid;
  logic [31:0]  wt;
  logic [31:0]  kt;
  logic [5:0]   round;
  logic         last;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0]  wcap [64];
  logic [31:0]  kcap [64];
  logic [31:0]  abc_ref [64];
  int           seq_err;
  int           last_err;
  logic         load_seen;
  logic         load_side_bad;

  localparam logic [511:0] ABC_BLK = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [31:0] IV [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  sha256_msg_sched dut (
    .clk         (clk),
    .rst         (rst),
    .blk_valid_i (blk_valid),
    .blk_ready_o (blk_ready),
    .blk_i       (blk),
    .load_o      (load),
    .wt_valid_o  (wt_valid),
    .Wt_o        (wt),
    .Kt_o        (kt),
    .round_o     (round),
    .last_o      (last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  // Compression of the captured W/K stream starting from the IV.
  function automatic logic [255:0] digest_of_capture();
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    a = IV[0]; b = IV[1]; c = IV[2]; d = IV[3];
    e = IV[4]; f = IV[5]; g = IV[6]; h = IV[7];
    for (int i = 0; i < 64; i++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g))
             + kcap[i] + wcap[i];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {IV[0] + a, IV[1] + b, IV[2] + c, IV[3] + d,
            IV[4] + e, IV[5] + f, IV[6] + g, IV[7] + h};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [511:0] b);
    blk       = b;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  // Entered one cycle after acceptance; records LOAD cycle then the 64 rounds.
  task automatic capture_rounds(input bit disturb);
    load_seen     = load;
    load_side_bad = blk_ready | wt_valid;
    if (disturb) begin
      blk_valid = 1'($urandom_range(0, 1));
      blk       = {16{$urandom}};
    end
    tick();
    seq_err  = 0;
    last_err = 0;
    for (int t = 0; t < 64; t++) begin
      if (wt_valid !== 1'b1 || round !== 6'(t) || load !== 1'b0 || blk_ready !== 1'b0)
        seq_err++;
      if (last !== (t == 63)) last_err++;
      wcap[t] = wt;
      kcap[t] = kt;
      if (disturb) begin
        blk_valid = 1'($urandom_range(0, 1));
        blk       = {16{$urandom}};
      end
      tick();
    end
    if (disturb) blk_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; blk_valid = 1'b0; blk = '0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (blk_ready !== 1'b1 || load !== 1'b0 || wt_valid !== 1'b0 || wt !== 32'h0 ||
          kt !== 32'h0 || round !== 6'h0 || last !== 1'b0) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: ready=%b load=%b valid=%b W=%h K=%h r=%0d last=%b, want 1 0 0 0 0 0 0",
                 i, blk_ready, load, wt_valid, wt, kt, round, last);
      end
      tick();
    end
  endtask

  task automatic test_abc();
    offer(ABC_BLK);
    capture_rounds(0);
    checks++;
    if (load_seen !== 1'b1 || load_side_bad !== 1'b0) begin
      errors++;
      $display("FAIL abc_load: load=%b side=%b, want 1 0", load_seen, load_side_bad);
    end
    checks++;
    if (seq_err != 0) begin
      errors++;
      $display("FAIL abc_seq: bad round cycles=%0d, want 0", seq_err);
    end
    checks++;
    if (last_err != 0) begin
      errors++;
      $display("FAIL abc_last: bad last cycles=%0d, want 0", last_err);
    end
    checks++;
    if (wcap[0] !== 32'h61626380 || wcap[15] !== 32'h00000018 ||
        wcap[16] !== 32'h61626380 || wcap[17] !== 32'h000F0000) begin
      errors++;
      $display("FAIL abc_w: W0=%h W15=%h W16=%h W17=%h, want 61626380 00000018 61626380 000f0000",
               wcap[0], wcap[15], wcap[16], wcap[17]);
    end
    checks++;
    if (kcap[0] !== 32'h428a2f98 || kcap[63] !== 32'hc67178f2) begin
      errors++;
      $display("FAIL abc_k: K0=%h K63=%h, want 428a2f98 c67178f2", kcap[0], kcap[63]);
    end
    checks++;
    if (digest_of_capture() !== ABC_DIGEST) begin
      errors++;
      $display("FAIL abc_digest: got %h want %h", digest_of_capture(), ABC_DIGEST);
    end
    checks++;
    if (blk_ready !== 1'b1 || wt_valid !== 1'b0 || load !== 1'b0) begin
      errors++;
      $display("FAIL abc_idle_after: ready=%b valid=%b load=%b, want 1 0 0", blk_ready, wt_valid, load);
    end
    for (int i = 0; i < 64; i++) abc_ref[i] = wcap[i];
  endtask

  task automatic test_back_to_back();
    logic [31:0]  m [16];
    logic [511:0] b2;
    logic [31:0]  w16_exp;
    int           acc1, acc2, n, leak;
    for (int i = 0; i < 16; i++) begin
      m[i] = 32'h0badf00d ^ (i * 32'h01010101);
      b2[511 - 32*i -: 32] = m[i];
    end
    w16_exp = ss1(m[14]) + m[9] + ss0(m[1]) + m[0];
    blk       = ABC_BLK;
    blk_valid = 1'b1;
    acc1      = cyc;
    tick();
    blk = b2;
    capture_rounds(0);
    n = 0;
    while (blk_ready !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    acc2 = cyc;
    checks++;
    if (acc2 - acc1 != 66) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d cycles, want 66", acc2 - acc1);
    end
    checks++;
    if (digest_of_capture() !== ABC_DIGEST) begin
      errors++;
      $display("FAIL b2b_first_digest: got %h want %h", digest_of_capture(), ABC_DIGEST);
    end
    tick();
    blk_valid = 1'b0;
    capture_rounds(0);
    checks++;
    if (load_seen !== 1'b1 || seq_err != 0) begin
      errors++;
      $display("FAIL b2b_second_stream: load=%b bad rounds=%0d, want 1 0", load_seen, seq_err);
    end
    checks++;
    if (wcap[0] !== m[0]) begin
      errors++;
      $display("FAIL b2b_w0: got %h want %h", wcap[0], m[0]);
    end
    leak = 0;
    for (int i = 0; i < 16; i++) if (wcap[i] !== m[i]) leak++;
    if (wcap[16] !== w16_exp) leak++;
    checks++;
    if (leak != 0) begin
      errors++;
      $display("FAIL b2b_leak: %0d words differ (W16 got %h want %h)", leak, wcap[16], w16_exp);
    end
  endtask

  task automatic test_reset_mid();
    int bad;
    offer(ABC_BLK);
    tick();
    repeat (30) tick();
    checks++;
    if (round !== 6'd30 || wt_valid !== 1'b1) begin
      errors++;
      $display("FAIL mid_at_t30: round=%0d valid=%b, want 30 1", round, wt_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (blk_ready !== 1'b1 || load !== 1'b0 || wt_valid !== 1'b0 || wt !== 32'h0 ||
        kt !== 32'h0 || round !== 6'h0 || last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_idle: ready=%b load=%b valid=%b W=%h K=%h r=%0d last=%b, want 1 0 0 0 0 0 0",
               blk_ready, load, wt_valid, wt, kt, round, last);
    end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (load !== 1'b0 || wt_valid !== 1'b0 || blk_ready !== 1'b1) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_no_resume: %0d active cycles after reset, want 0", bad);
    end
    offer(ABC_BLK);
    capture_rounds(0);
    checks++;
    if (load_seen !== 1'b1 || seq_err != 0 || wcap[0] !== 32'h61626380 ||
        wcap[17] !== 32'h000F0000 || digest_of_capture() !== ABC_DIGEST) begin
      errors++;
      $display("FAIL mid_fresh_abc: load=%b badrounds=%0d W0=%h W17=%h digest=%h",
               load_seen, seq_err, wcap[0], wcap[17], digest_of_capture());
    end
  endtask

  task automatic test_valid_ignored();
    int diff;
    offer(ABC_BLK);
    capture_rounds(1);
    diff = 0;
    for (int i = 0; i < 64; i++) if (wcap[i] !== abc_ref[i]) diff++;
    checks++;
    if (diff != 0 || seq_err != 0 || last_err != 0) begin
      errors++;
      $display("FAIL toggle_ignored: %0d words differ, badrounds=%0d badlast=%0d, want 0 0 0",
               diff, seq_err, last_err);
    end
    checks++;
    if (digest_of_capture() !== ABC_DIGEST) begin
      errors++;
      $display("FAIL toggle_digest: got %h want %h", digest_of_capture(), ABC_DIGEST);
    end
    tick();
    checks++;
    if (load !== 1'b0 || wt_valid !== 1'b0 || blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL toggle_idle: load=%b valid=%b ready=%b, want 0 0 1", load, wt_valid, blk_ready);
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_back_to_back();
    test_reset_mid();
    test_valid_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
